// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/BAUDDIV registers on the core's
// load/store port, a circular TX FIFO, and a serializer that drains it onto tx.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR       = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH      = 8,
  parameter logic [15:0] DEFAULT_BAUDDIV = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        W_en,
  input  logic        R_en,
  input  logic [31:0] addr,
  input  logic [2:0]  RW_type,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        sel,
  output logic        tx,
  output logic        tx_idle
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic [4:0]    count5;
  logic          ovf, full, empty, busy;
  logic [15:0]   bauddiv, div, bcnt;
  logic [1:0]    state, state_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [7:0]    shreg;
  logic          wr, push_req, push, pop, drop, bit_end;
  logic [31:0]   word, shifted;
  logic [15:0]   unused_din;

  function automatic logic [31:0] sext8(input logic signed [7:0] b);
    return 32'(b);
  endfunction

  function automatic logic [31:0] sext16(input logic signed [15:0] h);
    return 32'(h);
  endfunction

  assign unused_din = din[31:16];

  assign sel      = (addr[31:4] == BASE_ADDR[31:4]);
  assign wr       = W_en && sel;
  assign push_req = wr && (addr[3:2] == 2'd0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign busy     = (state != S_IDLE);
  assign bit_end  = (bcnt == div);
  assign count5   = 5'(count);

  // The serializer pops on leaving IDLE or at the end of a STOP bit; that pop frees a slot
  // for a push on the same edge, so a full FIFO only drops when no pop coincides.
  assign pop       = !empty && ((state == S_IDLE) || (state == S_STOP && bit_end));
  assign push      = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;
  assign count_nxt = count + CW'(push) - CW'(pop);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      S_IDLE:  if (!empty) state_nxt = S_START;
      S_START: if (bit_end) begin
        state_nxt = S_DATA;
        idx_nxt   = 3'd0;
      end
      S_DATA:  if (bit_end) begin
        if (idx == 3'd7) state_nxt = S_STOP;
        else             idx_nxt   = idx + 3'd1;
      end
      S_STOP:  if (bit_end) state_nxt = empty ? S_IDLE : S_START;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      tx      <= 1'b1;
      tx_idle <= 1'b1;
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ovf     <= 1'b0;
      bauddiv <= DEFAULT_BAUDDIV;
      div     <= DEFAULT_BAUDDIV;
      bcnt    <= '0;
      idx     <= '0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      count   <= count_nxt;
      tx_idle <= (count_nxt == '0) && (state_nxt == S_IDLE);
      bcnt    <= (state == S_IDLE || bit_end) ? 16'd0 : bcnt + 16'd1;
      case (state_nxt)
        S_START: tx <= 1'b0;
        S_DATA:  tx <= shreg[idx_nxt];
        default: tx <= 1'b1;
      endcase
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        div    <= bauddiv;
      end
      if (drop)
        ovf <= 1'b1;
      else if (wr && addr[3:2] == 2'd1 && din[3])
        ovf <= 1'b0;
      if (wr && addr[3:2] == 2'd2)
        bauddiv <= (din[15:0] == 16'd0) ? 16'd1 : din[15:0];
    end
  end

  // FIFO storage and shift register carry data only and need no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din[7:0];
    if (pop)  shreg <= mem[rd_ptr];
  end

  always_comb begin
    case (addr[3:2])
      2'd1:    word = {23'd0, count5, ovf, busy, empty, full};
      2'd2:    word = {16'd0, bauddiv};
      default: word = 32'd0;
    endcase
    shifted = word >> {addr[1:0], 3'b000};
    dout    = 32'd0;
    if (R_en && sel) begin
      case (RW_type)
        3'b000:  dout = sext8(shifted[7:0]);
        3'b001:  dout = sext16(shifted[15:0]);
        3'b100:  dout = {24'd0, shifted[7:0]};
        3'b101:  dout = {16'd0, shifted[15:0]};
        default: dout = word;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register access, serial waveform, FIFO full/overflow,
// push coinciding with pop, and reset in the middle of a frame.
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam logic [2:0] T_B = 3'b000, T_H = 3'b001, T_W = 3'b010, T_BU = 3'b100, T_HU = 3'b101;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        W_en = 1'b0, R_en = 1'b0;
  logic [31:0] addr = 32'd0, din = 32'd0;
  logic [2:0]  RW_type = 3'b010;
  logic [31:0] dout;
  logic        sel, tx, tx_idle;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  mmio_uart_tx dut (
    .clk(clk), .reset(reset), .W_en(W_en), .R_en(R_en), .addr(addr),
    .RW_type(RW_type), .din(din), .dout(dout), .sel(sel), .tx(tx), .tx_idle(tx_idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
    addr = a; din = d; RW_type = t; W_en = 1'b1;
    @(negedge clk);
    W_en = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] t, output logic [31:0] d);
    addr = a; RW_type = t; R_en = 1'b1;
    #1;
    d = dout;
    R_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Receives one frame at BAUDDIV=1 (two cycles per bit), sampling at negedges.
  task automatic rx_byte(output logic [7:0] b);
    for (int i = 0; i < 100 && tx !== 1'b0; i++) tick();
    chk("rx_start", {31'd0, tx}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick(); tick();
      b[i] = tx;
    end
    tick(); tick();
    chk("rx_stop", {31'd0, tx}, 32'd1);
  endtask

  logic [31:0] rd;
  logic [7:0]  rxb;
  logic [7:0]  pat [9] = '{8'h3C, 8'hA5, 8'h01, 8'h80, 8'hFF, 8'h00, 8'h5A, 8'hC3, 8'h96};
  logic [7:0]  expb;

  initial begin
    // Reset state
    tick(); tick();
    do_reset();
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_idle", {31'd0, tx_idle}, 32'd1);
    load(BASE + 32'h4, T_W, rd); chk("rst_status", rd, 32'h0000_0002);
    load(BASE + 32'h8, T_W, rd); chk("rst_baud", rd, 32'd434);
    load(32'h1000_0004, T_W, rd); chk("nosel_dout", rd, 32'd0);
    chk("nosel_sel", {31'd0, sel}, 32'd0);
    addr = BASE + 32'h4; #1;
    chk("sel", {31'd0, sel}, 32'd1);
    chk("no_ren_dout", dout, 32'd0);

    // One 0x55 frame at BAUDDIV=3
    store(BASE + 32'h8, 32'd3, T_W);
    store(BASE + 32'h0, 32'h0000_0055, T_W);
    chk("t1_busy_after_push", {31'd0, tx_idle}, 32'd0);
    for (int k = 1; k <= 41; k++) begin
      tick();
      if (k <= 4)       expb = 8'd0;
      else if (k <= 36) expb = {7'd0, ((8'h55 >> ((k - 5) / 4)) & 8'h01) != 8'h00};
      else              expb = 8'd1;
      chk($sformatf("t1_tx_k%0d", k), {31'd0, tx}, {24'd0, expb});
      chk($sformatf("t1_idle_k%0d", k), {31'd0, tx_idle}, (k >= 41) ? 32'd1 : 32'd0);
    end

    // Register lanes and extension
    store(BASE + 32'h8, 32'h0000_FF80, T_W);
    load(BASE + 32'h8, T_H, rd);  chk("lh_baud", rd, 32'hFFFF_FF80);
    load(BASE + 32'h8, T_HU, rd); chk("lhu_baud", rd, 32'h0000_FF80);
    load(BASE + 32'h9, T_BU, rd); chk("lbu_baud9", rd, 32'h0000_00FF);
    load(BASE + 32'h8, T_B, rd);  chk("lb_baud8", rd, 32'hFFFF_FF80);
    load(BASE + 32'hA, T_W, rd);  chk("lw_baud_a", rd, 32'h0000_FF80);
    load(BASE + 32'h0, T_W, rd);  chk("txdata_rd", rd, 32'd0);
    store(BASE + 32'hC, 32'hFFFF_FFFF, T_W);
    load(BASE + 32'hC, T_W, rd);  chk("reserved_rd", rd, 32'd0);
    store(BASE + 32'h8, 32'd0, T_W);
    load(BASE + 32'h8, T_W, rd);  chk("baud_zero_is_one", rd, 32'd1);
    store(32'h0000_0008, 32'd77, T_W);
    load(BASE + 32'h8, T_W, rd);  chk("nosel_write_ignored", rd, 32'd1);

    // Seven pushes at BAUDDIV=1000
    store(BASE + 32'h8, 32'd1000, T_W);
    for (int i = 0; i < 7; i++) store(BASE, {24'd0, pat[i]}, T_W);
    load(BASE + 32'h4, T_W, rd); chk("t2_status", rd, 32'h0000_0064);
    chk("t2_tx_start", {31'd0, tx}, 32'd0);

    // Reset in the middle of the data bits
    for (int i = 0; i < 1500; i++) tick();
    do_reset();
    chk("t6_tx", {31'd0, tx}, 32'd1);
    chk("t6_idle", {31'd0, tx_idle}, 32'd1);
    load(BASE + 32'h4, T_W, rd); chk("t6_status", rd, 32'h0000_0002);
    load(BASE + 32'h8, T_W, rd); chk("t6_baud", rd, 32'd434);
    for (int i = 0; i < 30; i++) tick();
    chk("t6_no_resume", {30'd0, tx, tx_idle}, 32'd3);

    // Fill, overflow, clear, then a push on the STOP-end pop edge
    store(BASE + 32'h8, 32'd1, T_W);
    for (int i = 0; i < 9; i++) store(BASE, {24'd0, pat[i]}, T_W);
    load(BASE + 32'h4, T_W, rd); chk("t3_full", rd, 32'h0000_0085);
    store(BASE, 32'h0000_00EE, T_W);
    load(BASE + 32'h4, T_W, rd); chk("t3_ovf", rd, 32'h0000_008D);
    store(BASE + 32'h4, 32'h0000_0008, T_W);
    load(BASE + 32'h4, T_W, rd); chk("t3_ovf_clr", rd, 32'h0000_0085);
    for (int i = 0; i < 10; i++) tick();
    store(BASE, 32'h0000_007E, T_W);
    load(BASE + 32'h4, T_W, rd); chk("t4_push_on_pop", rd, 32'h0000_0085);
    chk("t4_back_to_back", {31'd0, tx}, 32'd0);
    for (int i = 0; i < 19; i++) tick();
    for (int f = 0; f < 8; f++) begin
      rx_byte(rxb);
      expb = (f < 7) ? pat[f + 2] : 8'h7E;
      chk($sformatf("rx_byte%0d", f), {24'd0, rxb}, {24'd0, expb});
    end
    for (int i = 0; i < 100 && tx_idle !== 1'b1; i++) tick();
    chk("drain_idle", {31'd0, tx_idle}, 32'd1);
    load(BASE + 32'h4, T_W, rd); chk("drain_status", rd, 32'h0000_0002);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
